uart_tx: RTL

Serial transmitter stage directly downstream of the `baud` tick generator. It accepts parallel bytes over a valid/ready handshake, buffers one byte while another is shifting, and drives `baud`'s `i_run` input. It consumes the one-cycle `baud_en` tick to serialise each frame onto `o_tx`: start bit, LSB-first data, optional parity, then stop bit(s).

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding register in front of a shift register.
// Serialises start, LSB-first data, optional parity and stop bits, advancing
// one bit per baud_en tick. o_run drives the baud generator's run input.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line high, baud generator stopped, waiting for a held byte
// S_START  | driving the start bit (0)
// S_DATA   | driving data bits LSB first, bit_cnt counts ticks seen
// S_PARITY | driving the parity bit captured at load time
// S_STOP   | driving stop bit(s), bit_cnt counts stop ticks seen
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 baud_en,
    output logic                 o_run,
    output logic                 o_tx,
    output logic                 o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       PAR_ODD   = (PARITY == 2);

    state_t               state;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_full;
    logic [DATA_BITS-1:0] shift;
    logic [2:0]           bit_cnt;
    logic                 par_bit;

    logic accept;
    logic stop_done;
    logic load;
    logic hold_full_nxt;
    logic going_idle;

    // Handshake, load and next-occupancy decode shared by both registers blocks
    always_comb begin
        accept        = i_valid && o_ready;
        stop_done     = (state == S_STOP) && baud_en && (bit_cnt == LAST_STOP);
        load          = hold_full && ((state == S_IDLE) || stop_done);
        hold_full_nxt = hold_full;
        if (load)
            hold_full_nxt = 1'b0;
        if (accept)
            hold_full_nxt = 1'b1;
        going_idle    = !hold_full && ((state == S_IDLE) || stop_done);
    end

    // Holding register plus the ready/busy flags derived from its next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
            o_ready   <= 1'b1;
            o_busy    <= 1'b0;
        end else begin
            if (accept)
                hold <= i_data;
            hold_full <= hold_full_nxt;
            o_ready   <= ~hold_full_nxt;
            o_busy    <= !going_idle || hold_full_nxt;
        end
    end

    // Frame sequencer; o_tx is set to the level of the bit being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            o_tx    <= 1'b1;
            o_run   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hold_full) begin
                        state   <= S_START;
                        shift   <= hold;
                        par_bit <= (^hold) ^ PAR_ODD;
                        o_tx    <= 1'b0;
                        o_run   <= 1'b1;
                    end else begin
                        o_tx  <= 1'b1;
                        o_run <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_en) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                        o_tx    <= shift[0];
                    end
                end
                S_DATA: begin
                    if (baud_en) begin
                        shift <= shift >> 1;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                o_tx  <= par_bit;
                            end else begin
                                state <= S_STOP;
                                o_tx  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            o_tx    <= shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_en) begin
                        state   <= S_STOP;
                        bit_cnt <= '0;
                        o_tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_en) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            if (hold_full) begin
                                // back-to-back: o_run stays high so ticks stay aligned
                                state   <= S_START;
                                shift   <= hold;
                                par_bit <= (^hold) ^ PAR_ODD;
                                o_tx    <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                                o_tx  <= 1'b1;
                                o_run <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    o_tx  <= 1'b1;
                    o_run <= 1'b0;
                end
            endcase
        end
    end

endmodule
